// File: rtl/insert_tag_stream_arbiter.sv
// Packet-locked round-robin arbiter feeding one header inserter; tags each beat with the winner's segment and ID.
// Latency: one arbitration cycle per packet, then source beat to output 1 cycle; backpressure stalls the granted source only.
module insert_tag_stream_arbiter #(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int NUM_SOURCES       = 4,
  parameter int INSERT_SIZE_BYTES = 4,
  localparam int NUM_BUS_BYTES    = AXIS_BUS_WIDTH / 8,
  localparam int SRC_BITS         = ($clog2(NUM_SOURCES) < 1) ? 1 : $clog2(NUM_SOURCES),
  localparam int SEG_BITS         = INSERT_SIZE_BYTES * 8
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [NUM_SOURCES*AXIS_BUS_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SOURCES*NUM_BUS_BYTES-1:0]  s_axis_tkeep,
  input  logic [NUM_SOURCES-1:0]                s_axis_tlast,
  input  logic [NUM_SOURCES-1:0]                s_axis_tvalid,
  output logic [NUM_SOURCES-1:0]                s_axis_tready,
  input  logic [NUM_SOURCES*SEG_BITS-1:0]       cfg_insert_seg,
  input  logic [NUM_SOURCES-1:0]                cfg_src_enable,
  output logic [AXIS_BUS_WIDTH-1:0]             m_axis_tdata,
  output logic [NUM_BUS_BYTES-1:0]              m_axis_tkeep,
  output logic                                  m_axis_tlast,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [SEG_BITS-1:0]                   m_insert_seg,
  output logic [SRC_BITS-1:0]                   m_src_id,
  output logic                                  busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  typedef struct packed {
    logic [AXIS_BUS_WIDTH-1:0] dat;
    logic [NUM_BUS_BYTES-1:0]  keep;
    logic                      last;
  } hdr_t;

  typedef struct packed {
    logic [SEG_BITS-1:0] seg;
    logic [SRC_BITS-1:0] src;
  } meta_t;

  state_t              state_q, state_d;
  logic [SRC_BITS-1:0] grant_q, grant_d;
  logic [SRC_BITS-1:0] last_grant_q, last_grant_d;
  logic [SEG_BITS-1:0] seg_hold_q, seg_hold_d;
  logic                busy_q;

  logic                out_vld_q, out_vld_d;
  hdr_t                out_hdr_q, out_hdr_d;
  meta_t               out_meta_q, out_meta_d;

  logic [NUM_SOURCES-1:0] req;
  logic [SRC_BITS-1:0]    winner;
  logic [SRC_BITS-1:0]    scan_idx;
  logic                   found;
  logic [SEG_BITS-1:0]    winner_seg;

  hdr_t                   sel_hdr;
  logic                   sel_vld;
  logic                   pipe_ready;
  logic                   src_hs;

  assign req = s_axis_tvalid & cfg_src_enable;

  // Search starts just after the last packet's owner so every enabled source gets a turn.
  always_comb begin
    winner   = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      scan_idx = SRC_BITS'((int'(last_grant_q) + k) % NUM_SOURCES);
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_comb begin
    winner_seg = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (winner == SRC_BITS'(i)) begin
        winner_seg = cfg_insert_seg[i*SEG_BITS +: SEG_BITS];
      end
    end
  end

  always_comb begin
    sel_hdr = '0;
    sel_vld = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grant_q == SRC_BITS'(i)) begin
        sel_hdr.dat  = s_axis_tdata[i*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
        sel_hdr.keep = s_axis_tkeep[i*NUM_BUS_BYTES +: NUM_BUS_BYTES];
        sel_hdr.last = s_axis_tlast[i];
        sel_vld      = s_axis_tvalid[i];
      end
    end
  end

  assign pipe_ready = !out_vld_q || m_axis_tready;
  assign src_hs     = (state_q == STREAM) && pipe_ready && sel_vld;

  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      s_axis_tready[i] = (state_q == STREAM) && pipe_ready && (grant_q == SRC_BITS'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    seg_hold_d   = seg_hold_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = STREAM;
          grant_d    = winner;
          seg_hold_d = winner_seg;
        end
      end
      STREAM: begin
        if (src_hs && sel_hdr.last) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage drains on its own, so a held tlast beat can outlive the packet's STREAM state.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_hdr_d  = out_hdr_q;
    out_meta_d = out_meta_q;
    if (src_hs) begin
      out_vld_d      = 1'b1;
      out_hdr_d      = sel_hdr;
      out_meta_d.seg = seg_hold_q;
      out_meta_d.src = grant_q;
    end else if (m_axis_tready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_BITS'(NUM_SOURCES - 1);
      seg_hold_q   <= '0;
      busy_q       <= 1'b0;
      out_vld_q    <= 1'b0;
      out_hdr_q    <= '0;
      out_meta_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      seg_hold_q   <= seg_hold_d;
      busy_q       <= (state_d == STREAM);
      out_vld_q    <= out_vld_d;
      out_hdr_q    <= out_hdr_d;
      out_meta_q   <= out_meta_d;
    end
  end

  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_hdr_q.dat;
  assign m_axis_tkeep  = out_hdr_q.keep;
  assign m_axis_tlast  = out_hdr_q.last;
  assign m_insert_seg  = out_meta_q.seg;
  assign m_src_id      = out_meta_q.src;
  assign busy          = busy_q;

endmodule

// File: tb/tb_insert_tag_stream_arbiter.sv
// Random multi-source traffic against a packet-level arbiter model; expected beats are queued and checked by a monitor.
module tb_insert_tag_stream_arbiter;

  localparam int W   = 64;
  localparam int N   = 4;
  localparam int B   = W / 8;
  localparam int SEG = 32;
  localparam int SB  = 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [N*W-1:0]   s_axis_tdata = '0;
  logic [N*B-1:0]   s_axis_tkeep = '0;
  logic [N-1:0]     s_axis_tlast = '0;
  logic [N-1:0]     s_axis_tvalid = '0;
  logic [N-1:0]     s_axis_tready;
  logic [N*SEG-1:0] cfg_insert_seg = '0;
  logic [N-1:0]     cfg_src_enable = '1;
  logic [W-1:0]     m_axis_tdata;
  logic [B-1:0]     m_axis_tkeep;
  logic             m_axis_tlast;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b1;
  logic [SEG-1:0]   m_insert_seg;
  logic [SB-1:0]    m_src_id;
  logic             busy;

  insert_tag_stream_arbiter #(
    .AXIS_BUS_WIDTH(W), .NUM_SOURCES(N), .INSERT_SIZE_BYTES(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .cfg_insert_seg(cfg_insert_seg), .cfg_src_enable(cfg_src_enable),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_insert_seg(m_insert_seg), .m_src_id(m_src_id), .busy(busy)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic [W-1:0]   dat;
    logic [B-1:0]   keep;
    logic           last;
    logic [SEG-1:0] seg;
    int             src;
  } exp_t;

  exp_t expq[$];

  // Reference: one packet at a time, owner chosen round-robin among enabled requesters,
  // segment frozen at the choice, one output slot that frees when the sink takes it.
  int             m_ptr = N - 1;
  bit             m_busy = 1'b0;
  int             m_cur = 0;
  logic [SEG-1:0] m_seg = '0;
  bit             m_full = 1'b0;
  logic [N-1:0]   exp_rdy;
  logic [N-1:0]   m_req;
  bit             was_busy;
  exp_t           ne;

  always @(negedge aclk) begin
    if (!aresetn) begin
      m_ptr  = N - 1;
      m_busy = 1'b0;
      m_full = 1'b0;
      expq.delete();
    end else begin
      exp_rdy = '0;
      if (m_busy && (!m_full || m_axis_tready)) exp_rdy[m_cur] = 1'b1;
      chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
      chk("m_tvalid", 64'(m_axis_tvalid), 64'(m_full));
      chk("busy", 64'(busy), 64'(m_busy));
      was_busy = m_busy;
      if (m_busy && exp_rdy[m_cur] && s_axis_tvalid[m_cur]) begin
        ne.dat  = s_axis_tdata[m_cur*W +: W];
        ne.keep = s_axis_tkeep[m_cur*B +: B];
        ne.last = s_axis_tlast[m_cur];
        ne.seg  = m_seg;
        ne.src  = m_cur;
        expq.push_back(ne);
        m_full = 1'b1;
        if (ne.last) begin
          m_busy = 1'b0;
          m_ptr  = m_cur;
        end
      end else if (m_axis_tready) begin
        m_full = 1'b0;
      end
      if (!was_busy) begin
        m_req = s_axis_tvalid & cfg_src_enable;
        for (int k = 1; k <= N; k++) begin
          if (!m_busy && m_req[(m_ptr + k) % N]) begin
            m_busy = 1'b1;
            m_cur  = (m_ptr + k) % N;
            m_seg  = cfg_insert_seg[m_cur*SEG +: SEG];
          end
        end
      end
    end
  end

  exp_t got;
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (expq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_beat: got data %h src %0d with nothing expected at %0t",
                 m_axis_tdata, m_src_id, $time);
      end else begin
        got = expq.pop_front();
        chk("tdata", m_axis_tdata, got.dat);
        chk("tkeep", 64'(m_axis_tkeep), 64'(got.keep));
        chk("tlast", 64'(m_axis_tlast), 64'(got.last));
        chk("insert_seg", 64'(m_insert_seg), 64'(got.seg));
        chk("src_id", 64'(m_src_id), 64'(got.src));
      end
    end
  end

  // Traffic generator knobs
  logic [N-1:0] active = '0;
  bit           gen_on = 1'b1;
  int           vld_pct = 100;
  int           rdy_pct = 100;
  int           seg_chg_pct = 0;
  int           pkt_rem[N];
  logic [N-1:0] hs;

  task automatic step();
    int s;
    @(negedge aclk);
    hs = s_axis_tvalid & s_axis_tready;
    @(posedge aclk);
    #1;
    m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
    if ($urandom_range(0, 99) < seg_chg_pct) begin
      s = $urandom_range(0, N - 1);
      cfg_insert_seg[s*SEG +: SEG] = $urandom;
    end
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        pkt_rem[i]--;
        s_axis_tvalid[i] = 1'b0;
      end
      if (!s_axis_tvalid[i]) begin
        if (pkt_rem[i] == 0 && gen_on && active[i] && $urandom_range(0, 99) < vld_pct)
          pkt_rem[i] = $urandom_range(1, 4);
        if (pkt_rem[i] > 0 && $urandom_range(0, 99) < vld_pct) begin
          s_axis_tvalid[i]        = 1'b1;
          s_axis_tdata[i*W +: W]  = {$urandom, $urandom};
          s_axis_tkeep[i*B +: B]  = B'($urandom_range(0, 255));
          s_axis_tlast[i]         = (pkt_rem[i] == 1);
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pkt_rem[i] = 0;
      cfg_insert_seg[i*SEG +: SEG] = $urandom;
    end
    cfg_insert_seg[2*SEG +: SEG] = 32'hDEADBEEF;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_tkeep_tlast", 64'({m_axis_tkeep, m_axis_tlast}), 64'd0);
    chk("rst_seg_src", 64'({m_insert_seg, m_src_id}), 64'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;

    // Lone requester: re-granted every packet with the snapshotted segment
    active = 4'b0100;
    run(40);
    // Everyone saturating: strict rotation
    active = 4'b1111;
    run(200);
    // Only odd sources enabled, then one dropped while its packets may be in flight
    cfg_src_enable = 4'b1010;
    run(100);
    cfg_src_enable = 4'b1000;
    run(100);
    // Bursty sources, random sink backpressure, segment changes mid-packet
    cfg_src_enable = 4'b1111;
    vld_pct = 70;
    rdy_pct = 50;
    seg_chg_pct = 10;
    run(600);

    // Reset in the middle of a source-1 packet while source 0 is also requesting
    active = 4'b0011;
    vld_pct = 100;
    rdy_pct = 100;
    for (int c = 0; c < 200; c++) begin
      step();
      if (m_busy && m_cur == 1 && s_axis_tvalid[0] && s_axis_tvalid[1]) break;
    end
    aresetn = 1'b0;
    #1;
    chk("arst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("arst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    active = 4'b1111;
    vld_pct = 80;
    rdy_pct = 60;
    run(300);

    // Drain everything outstanding
    gen_on = 1'b0;
    vld_pct = 100;
    rdy_pct = 100;
    seg_chg_pct = 0;
    run(200);
    chk("queue_empty", 64'(expq.size()), 64'd0);
    chk("drained_valid", 64'(s_axis_tvalid), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
